ex_stage: RTL and testbench

Execute stage of the RV32I pipeline. It consumes the 4-bit ALU operation code produced by the ALU control decoder and the ID/EX operands, and resolves forwarding and operand-B selection. It computes the ALU result, zero flag, branch outcome and branch target, then registers everything into the EX/MEM pipeline register with stall and flush control. It is the stage directly downstream of ALU control and feeds the memory stage.

---
 rtl/riscv_pkg.sv | 35 +++
 rtl/alu_core.sv | 29 ++
 rtl/ex_stage.sv | 87 ++++++++
 tb/tb_ex_stage.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared ALU opcodes, forwarding encodings and EX/MEM record
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd3;
    localparam logic [3:0] ALU_SLL = 4'd4;
    localparam logic [3:0] ALU_SRL = 4'd5;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef struct packed {
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] store_data;
        logic [XLEN-1:0] branch_target;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            zero;
        logic            branch_taken;
        logic            illegal_op;
    } exmem_t;

    // 2'b11 falls back to the register file value
    function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel, input logic [XLEN-1:0] rf,
                                                input logic [XLEN-1:0] exmem, input logic [XLEN-1:0] memwb);
        return (sel == FWD_EXMEM) ? exmem : (sel == FWD_MEMWB) ? memwb : rf;
    endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational RV32I ALU with zero and illegal-opcode flags
module alu_core
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      operation,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);
    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (operation)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = a << b[4:0];
            ALU_SRL: result = a >> b[4:0];
            ALU_SUB: result = a - b;
            ALU_SRA: result = $signed(a) >>> b[4:0];
            default: illegal = 1'b1;
        endcase
    end

    assign zero = (result == '0);
endmodule

// File: rtl/ex_stage.sv
// ex_stage: operand forwarding, ALU, branch resolution and the EX/MEM register
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic [3:0]      operation,
    input  logic            alu_src,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      forward_a,
    input  logic [1:0]      forward_b,
    input  logic [XLEN-1:0] exmem_fwd_data,
    input  logic [XLEN-1:0] memwb_fwd_data,
    input  logic [4:0]      rd,
    input  logic            reg_write,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            mem_to_reg,
    input  logic            branch,
    output logic [XLEN-1:0] alu_result_q,
    output logic [XLEN-1:0] store_data_q,
    output logic [XLEN-1:0] branch_target_q,
    output logic [4:0]      rd_q,
    output logic            reg_write_q,
    output logic            mem_read_q,
    output logic            mem_write_q,
    output logic            mem_to_reg_q,
    output logic            zero_q,
    output logic            branch_taken_q,
    output logic            illegal_op_q
);
    import riscv_pkg::*;

    logic [XLEN-1:0] op_a, fb, op_b, alu_result;
    logic            alu_zero, alu_illegal;
    exmem_t          exmem_d, exmem_q;

    assign op_a = fwd_mux(forward_a, rs1_data, exmem_fwd_data, memwb_fwd_data);
    assign fb   = fwd_mux(forward_b, rs2_data, exmem_fwd_data, memwb_fwd_data);
    assign op_b = alu_src ? imm : fb;

    alu_core u_alu (
        .a         (op_a),
        .b         (op_b),
        .operation (operation),
        .result    (alu_result),
        .zero      (alu_zero),
        .illegal   (alu_illegal)
    );

    always_comb begin
        exmem_d               = '0;
        exmem_d.alu_result    = alu_result;
        exmem_d.store_data    = fb;
        exmem_d.branch_target = pc + imm;
        exmem_d.rd            = rd;
        exmem_d.reg_write     = reg_write;
        exmem_d.mem_read      = mem_read;
        exmem_d.mem_write     = mem_write;
        exmem_d.mem_to_reg    = mem_to_reg;
        exmem_d.zero          = alu_zero;
        exmem_d.branch_taken  = branch & alu_zero;
        exmem_d.illegal_op    = alu_illegal;
    end

    // flush loads an all-zero bubble and overrides stall
    always_ff @(posedge clk) begin
        exmem_q <= (reset || flush) ? '0 : stall ? exmem_q : exmem_d;
    end

    assign alu_result_q    = exmem_q.alu_result;
    assign store_data_q    = exmem_q.store_data;
    assign branch_target_q = exmem_q.branch_target;
    assign rd_q            = exmem_q.rd;
    assign reg_write_q     = exmem_q.reg_write;
    assign mem_read_q      = exmem_q.mem_read;
    assign mem_write_q     = exmem_q.mem_write;
    assign mem_to_reg_q    = exmem_q.mem_to_reg;
    assign zero_q          = exmem_q.zero;
    assign branch_taken_q  = exmem_q.branch_taken;
    assign illegal_op_q    = exmem_q.illegal_op;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed and randomized checks of ex_stage against an arithmetic reference model
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        reset, stall, flush, alu_src;
    logic [3:0]  operation;
    logic [31:0] rs1_data, rs2_data, imm, pc, exmem_fwd_data, memwb_fwd_data;
    logic [1:0]  forward_a, forward_b;
    logic [4:0]  rd;
    logic        reg_write, mem_read, mem_write, mem_to_reg, branch;
    logic [31:0] alu_result_q, store_data_q, branch_target_q;
    logic [4:0]  rd_q;
    logic        reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q, zero_q, branch_taken_q, illegal_op_q;

    logic [31:0] e_res, e_sd, e_bt;
    logic [4:0]  e_rd;
    logic        e_rw, e_mr, e_mw, e_mtr, e_z, e_tk, e_ill;
    int          checks = 0;
    int          errors = 0;

    ex_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .operation(operation), .alu_src(alu_src),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
        .forward_a(forward_a), .forward_b(forward_b),
        .exmem_fwd_data(exmem_fwd_data), .memwb_fwd_data(memwb_fwd_data),
        .rd(rd), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .branch(branch),
        .alu_result_q(alu_result_q), .store_data_q(store_data_q), .branch_target_q(branch_target_q),
        .rd_q(rd_q), .reg_write_q(reg_write_q), .mem_read_q(mem_read_q), .mem_write_q(mem_write_q),
        .mem_to_reg_q(mem_to_reg_q), .zero_q(zero_q), .branch_taken_q(branch_taken_q),
        .illegal_op_q(illegal_op_q)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] rf);
        if (s == 2'b10) return exmem_fwd_data;
        if (s == 2'b01) return memwb_fwd_data;
        return rf;
    endfunction

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh = b % 32;
        logic [63:0] ext = {{32{a[31]}}, a};
        case (op)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a + b;
            4'd3: return a ^ b;
            4'd4: return 32'(64'(a) * (64'd1 << sh));
            4'd5: return a / (32'd1 << sh);
            4'd6: return a - b;
            4'd7: return ext[31:0] >> sh | (ext >> sh) >> 0 & 64'hFFFF_FFFF;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        logic [31:0] a, fb, b, r;
        a  = pick(forward_a, rs1_data);
        fb = pick(forward_b, rs2_data);
        b  = alu_src ? imm : fb;
        r  = alu_model(operation, a, b);
        if (reset || flush) begin
            {e_res, e_sd, e_bt, e_rd} = '0;
            {e_rw, e_mr, e_mw, e_mtr, e_z, e_tk, e_ill} = '0;
        end else if (!stall) begin
            e_res = r; e_sd = fb; e_bt = pc + imm; e_rd = rd;
            e_rw = reg_write; e_mr = mem_read; e_mw = mem_write; e_mtr = mem_to_reg;
            e_z = (r == 0); e_tk = branch && (r == 0); e_ill = (operation > 4'd7);
        end
        @(posedge clk);
        #1;
        chk("alu_result", alu_result_q, e_res);
        chk("store_data", store_data_q, e_sd);
        chk("branch_target", branch_target_q, e_bt);
        chk("rd", 32'(rd_q), 32'(e_rd));
        chk("ctrl", {28'd0, reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q}, {28'd0, e_rw, e_mr, e_mw, e_mtr});
        chk("zero", 32'(zero_q), 32'(e_z));
        chk("branch_taken", 32'(branch_taken_q), 32'(e_tk));
        chk("illegal_op", 32'(illegal_op_q), 32'(e_ill));
    endtask

    task automatic rand_inputs;
        operation = 4'($urandom_range(0, 15));
        alu_src = 1'($urandom); forward_a = 2'($urandom); forward_b = 2'($urandom);
        rs1_data = $urandom; rs2_data = $urandom; imm = $urandom; pc = $urandom;
        exmem_fwd_data = $urandom; memwb_fwd_data = $urandom;
        if ($urandom_range(0, 3) == 0) rs2_data = rs1_data;
        rd = 5'($urandom);
        {reg_write, mem_read, mem_write, mem_to_reg, branch} = 5'($urandom);
    endtask

    task automatic clear_ctrl;
        reset = 0; stall = 0; flush = 0; forward_a = 0; forward_b = 0;
        {reg_write, mem_read, mem_write, mem_to_reg, branch} = '0;
    endtask

    initial begin
        reset = 1; stall = 1; flush = 1; operation = 4'd2; alu_src = 1;
        rs1_data = 32'h11; rs2_data = 32'h22; imm = 32'h33; pc = 32'h44;
        forward_a = 2'b11; forward_b = 2'b11; exmem_fwd_data = 32'h55; memwb_fwd_data = 32'h66;
        rd = 5'd7; {reg_write, mem_read, mem_write, mem_to_reg, branch} = 5'b11111;
        step;
        chk("reset_result", alu_result_q, 32'd0);

        clear_ctrl; operation = 4'd2; rs1_data = 5; alu_src = 1; imm = 7; rd = 5'd3; reg_write = 1;
        step;
        chk("add_5_7", alu_result_q, 32'd12);

        operation = 4'd6; rs1_data = 32'h10; rs2_data = 32'h10; alu_src = 0;
        branch = 1; reg_write = 0; pc = 32'h100; imm = 32'h20;
        step;
        chk("beq_taken", 32'(branch_taken_q), 32'd1);
        chk("beq_target", branch_target_q, 32'h120);

        clear_ctrl; alu_src = 1; imm = 33; rs1_data = 32'h8000_0000;
        operation = 4'd7; step; chk("sra", alu_result_q, 32'hC000_0000);
        operation = 4'd5; step; chk("srl", alu_result_q, 32'h4000_0000);
        operation = 4'd4; rs1_data = 1; step; chk("sll", alu_result_q, 32'd2);

        operation = 4'd1; forward_a = 2'b10; exmem_fwd_data = 32'hAAAA_0000;
        forward_b = 2'b01; memwb_fwd_data = 32'h0000_FFFF; alu_src = 0; rs1_data = 32'h1; rs2_data = 32'h2;
        step;
        chk("fwd_or", alu_result_q, 32'hAAAA_FFFF);
        chk("fwd_store", store_data_q, 32'h0000_FFFF);
        alu_src = 1; imm = 32'h1234_5678;
        step;
        chk("fwd_store_imm", store_data_q, 32'h0000_FFFF);

        for (int i = 0; i < 3; i++) begin
            rand_inputs; stall = 1; flush = 0; reset = 0;
            step;
            chk("stall_hold", store_data_q, 32'h0000_FFFF);
        end

        rand_inputs; stall = 1; flush = 1; reg_write = 1; mem_read = 1; rd = 5'd9;
        step;
        chk("bubble_rd", 32'(rd_q), 32'd0);

        clear_ctrl; operation = 4'd9; mem_write = 1; rs1_data = 3; rs2_data = 4; alu_src = 0;
        step;
        chk("illegal_flag", 32'(illegal_op_q), 32'd1);
        chk("illegal_mem_write", 32'(mem_write_q), 32'd1);
        operation = 4'd0; mem_write = 0;
        step;
        chk("illegal_cleared", 32'(illegal_op_q), 32'd0);

        for (int i = 0; i < 400; i++) begin
            rand_inputs;
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 31) == 0);
            step;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
